// File: rtl/johnson_pkg.sv
// Shared types and helpers for Johnson (twisted-ring) counter consumers.
package johnson_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } jstate_e;

    localparam int JOHNSON_N  = 4;
    localparam int RING_LEN   = 2 * JOHNSON_N;
    localparam int IDX_W      = $clog2(RING_LEN);
    localparam int CODE_MAX_W = 32;

    // A Johnson word has at most one 0/1 boundary between adjacent bits.
    function automatic logic johnson_legal(input logic [CODE_MAX_W-1:0] code, input int n);
        int edges;
        edges = 0;
        for (int i = 0; i < CODE_MAX_W - 1; i++) begin
            if ((i + 1 < n) && (code[i] != code[i+1])) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson word to ring index decoder with legality flag.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int N      = JOHNSON_N,
    parameter int IDX_W  = $clog2(2 * N)
) (
    input  logic [N-1:0]     code,
    output logic [IDX_W-1:0] idx,
    output logic             legal
);

    int ones;

    always_comb begin
        ones = 0;
        for (int i = 0; i < N; i++) begin
            ones += int'(code[i]);
        end
        legal = johnson_legal(CODE_MAX_W'(code), N);
        // Filling half counts ones upward; draining half counts down from 2N.
        if ((code == '0) || code[N-1]) begin
            idx = IDX_W'(ones);
        end else begin
            idx = IDX_W'(2 * N - ones);
        end
    end

endmodule

// File: rtl/johnson_seq_monitor.sv
// Johnson stream decoder plus ring-order integrity monitor; all outputs registered one cycle after the beat.
module johnson_seq_monitor
    import johnson_pkg::*;
#(
    parameter int N        = JOHNSON_N,
    parameter int LOCK_CNT = 3,
    parameter int HOLD_OK  = 0,
    parameter int ERRW     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      code_valid,
    input  logic [N-1:0]              code,
    input  logic                      clr_err,
    output logic [$clog2(2*N)-1:0]    phase,
    output logic                      phase_valid,
    output logic                      locked,
    output logic                      seq_err,
    output logic                      illegal_err,
    output logic                      wrap,
    output logic [ERRW-1:0]           err_count
);

    localparam int RING = 2 * N;
    localparam int IW   = $clog2(RING);
    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

    logic [IW-1:0] dec_idx;
    logic          dec_legal;

    johnson_code_decode #(
        .N     (N),
        .IDX_W (IW)
    ) u_decode (
        .code  (code),
        .idx   (dec_idx),
        .legal (dec_legal)
    );

    jstate_e       state_q, state_d;
    logic [IW-1:0] phase_q, phase_d;
    logic [3:0]    good_cnt_q, good_cnt_d;
    logic [ERRW-1:0] err_count_q, err_count_d;
    logic          phase_valid_q, phase_valid_d;
    logic          locked_q, locked_d;
    logic          seq_err_q, seq_err_d;
    logic          illegal_err_q, illegal_err_d;
    logic          wrap_q, wrap_d;

    logic [IW-1:0] exp_idx;
    logic          is_succ;
    logic          is_hold;
    logic          err_inc;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        good_cnt_d    = good_cnt_q;
        err_count_d   = err_count_q;
        phase_valid_d = 1'b0;
        seq_err_d     = 1'b0;
        illegal_err_d = 1'b0;
        wrap_d        = 1'b0;

        exp_idx = (phase_q == IW'(RING - 1)) ? '0 : phase_q + 1'b1;
        is_succ = (dec_idx == exp_idx);
        is_hold = (HOLD_OK != 0) && (dec_idx == phase_q);

        if (code_valid) begin
            if (!dec_legal) begin
                illegal_err_d = 1'b1;
                state_d       = UNLOCKED;
                good_cnt_d    = '0;
            end else begin
                phase_valid_d = 1'b1;
                phase_d       = dec_idx;
                unique case (state_q)
                    UNLOCKED: begin
                        state_d    = LOCKING;
                        good_cnt_d = '0;
                    end
                    LOCKING: begin
                        if (is_succ) begin
                            good_cnt_d = good_cnt_q + 4'd1;
                            if (good_cnt_d == 4'(LOCK_CNT)) begin
                                state_d = LOCKED;
                            end
                        end else if (!is_hold) begin
                            // Wrong successor while acquiring: silently re-anchor.
                            good_cnt_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (is_succ) begin
                            wrap_d = (phase_q == IW'(RING - 1));
                        end else if (!is_hold) begin
                            seq_err_d  = 1'b1;
                            state_d    = LOCKING;
                            good_cnt_d = '0;
                        end
                    end
                    default: begin
                        state_d    = UNLOCKED;
                        good_cnt_d = '0;
                    end
                endcase
            end
        end

        err_inc = seq_err_d | illegal_err_d;
        if (clr_err) begin
            err_count_d = ERRW'(err_inc);
        end else if (err_inc && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + 1'b1;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= UNLOCKED;
            phase_q       <= '0;
            good_cnt_q    <= '0;
            err_count_q   <= '0;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            seq_err_q     <= 1'b0;
            illegal_err_q <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            good_cnt_q    <= good_cnt_d;
            err_count_q   <= err_count_d;
            phase_valid_q <= phase_valid_d;
            locked_q      <= locked_d;
            seq_err_q     <= seq_err_d;
            illegal_err_q <= illegal_err_d;
            wrap_q        <= wrap_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign locked      = locked_q;
    assign seq_err     = seq_err_q;
    assign illegal_err = illegal_err_q;
    assign wrap        = wrap_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Bench: three monitor variants (default, hold-tolerant, 2-bit error counter) on one shared stream.
module tb_johnson_seq_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       code_valid;
    logic [3:0] code;
    logic       clr_err;

    logic [2:0] ph0, ph1, ph2;
    logic       pv0, pv1, pv2, lk0, lk1, lk2, se0, se1, se2;
    logic       ie0, ie1, ie2, wr0, wr1, wr2;
    logic [7:0] ec0, ec1;
    logic [1:0] ec2;

    always #5 clk = ~clk;

    johnson_seq_monitor #(.N(4), .LOCK_CNT(3), .HOLD_OK(0), .ERRW(8)) dut0 (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code(code), .clr_err(clr_err),
        .phase(ph0), .phase_valid(pv0), .locked(lk0), .seq_err(se0),
        .illegal_err(ie0), .wrap(wr0), .err_count(ec0));

    johnson_seq_monitor #(.N(4), .LOCK_CNT(3), .HOLD_OK(1), .ERRW(8)) dut1 (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code(code), .clr_err(clr_err),
        .phase(ph1), .phase_valid(pv1), .locked(lk1), .seq_err(se1),
        .illegal_err(ie1), .wrap(wr1), .err_count(ec1));

    johnson_seq_monitor #(.N(4), .LOCK_CNT(3), .HOLD_OK(0), .ERRW(2)) dut2 (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code(code), .clr_err(clr_err),
        .phase(ph2), .phase_valid(pv2), .locked(lk2), .seq_err(se2),
        .illegal_err(ie2), .wrap(wr2), .err_count(ec2));

    typedef struct {
        int st;     // 0 unlocked, 1 locking, 2 locked
        int phase;
        int good;
        int errc;
        bit pv;
        bit lk;
        bit se;
        bit ie;
        bit wr;
    } mdl_t;

    localparam logic [3:0] RING_TAB [8] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
    localparam bit         HOLD     [3] = '{1'b0, 1'b1, 1'b0};
    localparam int         EMAX     [3] = '{255, 255, 3};
    localparam int         LOCK     = 3;

    mdl_t m [3];
    mdl_t exp_q [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        if (obs != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = 0; r.phase = 0; r.good = 0; r.errc = 0;
        r.pv = 0; r.lk = 0; r.se = 0; r.ie = 0; r.wr = 0;
        return r;
    endfunction

    // Reference: table lookup decode, explicit ring arithmetic.
    function automatic mdl_t mstep(input mdl_t mi, input bit v, input logic [3:0] c,
                                   input bit clr, input bit hold, input int emax);
        mdl_t r;
        int   idx;
        bit   succ, hld;
        r = mi;
        r.pv = 0; r.se = 0; r.ie = 0; r.wr = 0;
        if (v) begin
            idx = -1;
            for (int i = 0; i < 8; i++) if (RING_TAB[i] == c) idx = i;
            if (idx < 0) begin
                r.ie = 1; r.st = 0; r.good = 0;
            end else begin
                r.pv = 1;
                r.phase = idx;
                succ = (idx == (mi.phase + 1) % 8);
                hld  = hold && (idx == mi.phase);
                if (mi.st == 0) begin
                    r.st = 1; r.good = 0;
                end else if (mi.st == 1) begin
                    if (succ) begin
                        r.good = mi.good + 1;
                        if (r.good == LOCK) r.st = 2;
                    end else if (!hld) r.good = 0;
                end else begin
                    if (succ) r.wr = (mi.phase == 7);
                    else if (!hld) begin r.se = 1; r.st = 1; r.good = 0; end
                end
            end
        end
        if (clr) r.errc = (r.se || r.ie) ? 1 : 0;
        else if ((r.se || r.ie) && r.errc < emax) r.errc = r.errc + 1;
        r.lk = (r.st == 2);
        return r;
    endfunction

    task automatic check_outs(input string nm, input mdl_t e, input int ph, input int pv,
                              input int lk, input int se, input int ie, input int wr, input int ec);
        chk({nm, ".phase"}, ph, e.phase);
        chk({nm, ".phase_valid"}, pv, int'(e.pv));
        chk({nm, ".locked"}, lk, int'(e.lk));
        chk({nm, ".seq_err"}, se, int'(e.se));
        chk({nm, ".illegal_err"}, ie, int'(e.ie));
        chk({nm, ".wrap"}, wr, int'(e.wr));
        chk({nm, ".err_count"}, ec, e.errc);
    endtask

    task automatic check_all(input mdl_t e0, input mdl_t e1, input mdl_t e2);
        check_outs("d0", e0, int'(ph0), int'(pv0), int'(lk0), int'(se0), int'(ie0), int'(wr0), int'(ec0));
        check_outs("d1", e1, int'(ph1), int'(pv1), int'(lk1), int'(se1), int'(ie1), int'(wr1), int'(ec1));
        check_outs("d2", e2, int'(ph2), int'(pv2), int'(lk2), int'(se2), int'(ie2), int'(wr2), int'(ec2));
    endtask

    task automatic beat(input bit v, input logic [3:0] c, input bit clr);
        mdl_t e0, e1, e2;
        @(negedge clk);
        code_valid = v;
        code       = c;
        clr_err    = clr;
        for (int k = 0; k < 3; k++) begin
            m[k] = mstep(m[k], v, c, clr, HOLD[k], EMAX[k]);
            exp_q.push_back(m[k]);
        end
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        clr_err    = 1'b0;
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        check_all(e0, e1, e2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; code_valid = 1'b0; code = 4'h0; clr_err = 1'b0;
        for (int k = 0; k < 3; k++) m[k] = mreset();
        repeat (3) @(posedge clk);
        #1;
        check_all(m[0], m[1], m[2]);
        @(negedge clk);
        rst = 1'b0;

        // Full legal ring from 0 back to 0: locks after idx 3, wraps on 1 -> 0.
        for (int i = 0; i <= 8; i++) beat(1'b1, RING_TAB[i % 8], 1'b0);
        chk("ring.locked", int'(lk0), 1);
        chk("ring.err_count", int'(ec0), 0);

        // Illegal word while locked.
        beat(1'b1, 4'h5, 1'b0);
        chk("illegal.phase_hold", int'(ph0), 0);
        chk("illegal.err_count", int'(ec0), 1);

        // Idle beat with garbage on code must not disturb anything.
        beat(1'b0, 4'hA, 1'b0);

        // Relock at 12, then skip 14.
        beat(1'b1, 4'h1, 1'b0);
        beat(1'b1, 4'h0, 1'b0);
        beat(1'b1, 4'h8, 1'b0);
        beat(1'b1, 4'hC, 1'b0);
        chk("skip.pre_locked", int'(lk0), 1);
        beat(1'b1, 4'hF, 1'b0);
        chk("skip.seq_err", int'(se0), 1);
        chk("skip.phase", int'(ph0), 4);
        beat(1'b1, 4'h7, 1'b0);
        beat(1'b1, 4'h3, 1'b0);
        beat(1'b1, 4'h1, 1'b0);
        chk("skip.relocked", int'(lk0), 1);

        // Repeat of 8 while locked: error without hold, stall with hold.
        beat(1'b1, 4'h0, 1'b0);
        beat(1'b1, 4'h8, 1'b0);
        beat(1'b1, 4'h8, 1'b0);
        chk("repeat.d0_seq_err", int'(se0), 1);
        chk("repeat.d1_locked", int'(lk1), 1);

        // Five illegal words saturate the 2-bit counter.
        beat(1'b1, 4'h5, 1'b0);
        beat(1'b1, 4'h9, 1'b0);
        beat(1'b1, 4'h2, 1'b0);
        beat(1'b1, 4'h6, 1'b0);
        beat(1'b1, 4'hA, 1'b0);
        chk("sat.d2_err_count", int'(ec2), 3);
        beat(1'b1, 4'hD, 1'b1);
        chk("clr_with_err.d2", int'(ec2), 1);
        beat(1'b0, 4'h0, 1'b1);
        chk("clr_alone.d0", int'(ec0), 0);

        // Lock again and abort with an asynchronous reset between edges.
        beat(1'b1, 4'h0, 1'b0);
        beat(1'b1, 4'h8, 1'b0);
        beat(1'b1, 4'hC, 1'b0);
        beat(1'b1, 4'hE, 1'b0);
        beat(1'b1, 4'hF, 1'b0);
        chk("prereset.locked", int'(lk0), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) m[k] = mreset();
        check_all(m[0], m[1], m[2]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First code after reset is only an anchor.
        beat(1'b1, 4'h3, 1'b0);
        chk("postreset.phase", int'(ph0), 6);
        chk("postreset.locked", int'(lk0), 0);
        beat(1'b1, 4'h1, 1'b0);
        beat(1'b1, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
